// File: rtl/program_counter_stack_pkg.sv
// Shared definitions for the program counter / return stack block:
// default geometry, the operation encoding used by the priority decoder,
// and the decoder itself so every user resolves requests identically.
package program_counter_stack_pkg;

  // Default geometry of the PC and the return stack.
  localparam int PCS_DEF_WIDTH = 4;
  localparam int PCS_DEF_DEPTH = 4;

  // Operation selected for a clock edge. The numeric order follows the
  // priority (higher code wins) except CONFLICT, which overrides everything.
  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_CP       = 3'd1,
    OP_LOAD     = 3'd2,
    OP_RET      = 3'd3,
    OP_CALL     = 3'd4,
    OP_CONFLICT = 3'd5
  } pcs_op_e;

  // Resolve the raw request lines into the single operation executed this
  // edge: call > ret > load > cp, with call+ret together being an error
  // that suppresses every other request.
  function automatic pcs_op_e pcs_decode_op(
    input logic i_call,
    input logic i_ret,
    input logic i_load,
    input logic i_cp
  );
    pcs_op_e v_op;
    if (i_call && i_ret) begin
      v_op = OP_CONFLICT;
    end else if (i_call) begin
      v_op = OP_CALL;
    end else if (i_ret) begin
      v_op = OP_RET;
    end else if (i_load) begin
      v_op = OP_LOAD;
    end else if (i_cp) begin
      v_op = OP_CP;
    end else begin
      v_op = OP_IDLE;
    end
    return v_op;
  endfunction

endpackage

// File: rtl/program_counter_stack_pc_stack.sv
// LIFO return-address stack. Only the occupancy pointer is reset; entry
// storage is never cleared because an entry is only readable after a push.
module pc_stack
  import program_counter_stack_pkg::*;
#(
  parameter int WIDTH = PCS_DEF_WIDTH,
  parameter int DEPTH = PCS_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  // Pointer counts occupancy 0..DEPTH; storage index needs at least one bit.
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_top;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard requests so an overflowing push or underflowing pop is a no-op.
  always_comb begin
    w_do_push = push && !full;
    w_do_pop  = pop && !empty && !push;
    w_top     = r_ptr - PW'(1);
  end

  // Occupancy pointer; cleared by reset, moves by one per accepted op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - PW'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Entry storage: write the pushed return address at the current pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_ptr[AW-1:0]] <= din;
    end
  end

  assign dout  = r_mem[w_top[AW-1:0]];
  assign empty = (r_ptr == '0);
  assign full  = (r_ptr == PW'(DEPTH));

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with call/return stack and a tristate bus interface.
// Holds the PC register, the request priority decode, the sticky error
// flag and the bus driver; return addresses live in pc_stack.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int WIDTH = PCS_DEF_WIDTH,
  parameter int DEPTH = PCS_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cp,
  input  logic             enable,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  inout  wire  [WIDTH-1:0] w_bus,
  output logic [WIDTH-1:0] pc_out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  logic [WIDTH-1:0] r_pc;
  logic             r_err;
  pcs_op_e          w_op;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_stack_dout;
  logic             w_stack_empty;
  logic             w_stack_full;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;

  // Return stack; pushes PC+1 on call, supplies the return target on ret.
  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_stack_dout),
    .empty (w_stack_empty),
    .full  (w_stack_full)
  );

  // Pick this edge's single operation and derive next PC, stack strobes
  // and error condition from it.
  always_comb begin
    w_op      = pcs_decode_op(call, ret, load, cp);
    w_pc_inc  = r_pc + WIDTH'(1);
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    case (w_op)
      OP_CP: begin
        w_pc_next = w_pc_inc;
      end
      OP_LOAD: begin
        // With enable high the bus carries the PC itself, so this holds.
        w_pc_next = w_bus;
      end
      OP_CALL: begin
        if (w_stack_full) begin
          w_err_set = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_pc_next = w_bus;
        end
      end
      OP_RET: begin
        if (w_stack_empty) begin
          w_err_set = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_pc_next = w_stack_dout;
        end
      end
      OP_CONFLICT: begin
        w_err_set = 1'b1;
      end
      default: begin
        w_pc_next = r_pc;
      end
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky error flag: set by overflow, underflow or call/ret conflict,
  // cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign pc_out      = r_pc;
  assign stack_err   = r_err;
  assign stack_empty = w_stack_empty;
  assign stack_full  = w_stack_full;

  // Bus driver: PC while enabled (including during reset), released otherwise.
  assign w_bus = enable ? r_pc : {WIDTH{1'bz}};

endmodule
